// File: rtl/instr_sequencer_if.sv
// Instruction stream between the sequencer and the opcode-decoding consumer.
// The sequencer drives opcode/operand with instr_valid; the consumer answers
// with instr_ready. A transfer happens on any rising edge where both are high.
interface instr_sequencer_if #(
   parameter int unsigned DATA_W = 8
);
   logic              instr_valid;
   logic              instr_ready;
   logic [3:0]        opcode;
   logic [DATA_W-1:0] operand;

   modport master (
      output instr_valid,
      output opcode,
      output operand,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  opcode,
      input  operand,
      output instr_ready
   );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: holds a small {opcode, operand} program and issues it, one
// word per valid/ready transfer, starting at address 0 on start. A run ends on
// HALT_OP (never issued), on abort, or after the last address (overrun).
// Optional build macro SEQ_SKIP_NOP_EN: opcode 4'h0 is consumed internally
// without a handshake instead of being issued.
module instr_sequencer #(
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned DATA_W  = 8,
   parameter logic [3:0]  HALT_OP = 4'hF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                prog_we_i,
   input  logic [ADDR_W-1:0]   prog_addr_i,
   input  logic [4+DATA_W-1:0] prog_data_i,
   input  logic                start_i,
   input  logic                abort_i,
   instr_sequencer_if.master   bus,
   output logic [ADDR_W-1:0]   pc_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                overrun_o
);

   localparam int unsigned DEPTH  = 2 ** ADDR_W;
   localparam int unsigned WORD_W = 4 + DATA_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_ISSUE = 2'd2;

   logic [WORD_W-1:0] mem_q [DEPTH];

   logic [1:0]        state_q,   state_d;
   logic [ADDR_W-1:0] pc_q,      pc_d;
   logic [3:0]        opcode_q,  opcode_d;
   logic [DATA_W-1:0] operand_q, operand_d;
   logic              done_q,    done_d;
   logic              overrun_q, overrun_d;

   logic              is_halt;
   logic              is_skip;
   logic              issue_valid;
   logic              advance;
   logic              at_last;

   assign is_halt = (opcode_q == HALT_OP);
`ifdef SEQ_SKIP_NOP_EN
   assign is_skip = (opcode_q == 4'h0) && !is_halt;
`else
   assign is_skip = 1'b0;
`endif
   assign at_last     = (pc_q == '1);
   assign issue_valid = (state_q == S_ISSUE) && !is_halt && !is_skip;
   // A skipped NOP advances exactly like a completed handshake.
   assign advance     = (state_q == S_ISSUE) && !is_halt && (is_skip || bus.instr_ready);

   // Program store: writable only while idle, no reset on contents.
   always_ff @(posedge clk) begin
      if (prog_we_i && (state_q == S_IDLE)) begin
         mem_q[prog_addr_i] <= prog_data_i;
      end
   end

   // Next-state logic; abort is applied last so it overrides every other event.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      opcode_d  = opcode_q;
      operand_d = operand_q;
      done_d    = 1'b0;
      overrun_d = overrun_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d   = S_FETCH;
               pc_d      = '0;
               overrun_d = 1'b0;
            end
         end
         S_FETCH: begin
            {opcode_d, operand_d} = mem_q[pc_q];
            state_d               = S_ISSUE;
         end
         S_ISSUE: begin
            if (is_halt) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (advance) begin
               if (at_last) begin
                  overrun_d = 1'b1;
                  done_d    = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  pc_d    = pc_q + 1'b1;
                  state_d = S_FETCH;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // An aborted transfer still counts as taken by the consumer, but the
      // run stops without advancing pc or touching the captured word.
      if (abort_i) begin
         state_d   = S_IDLE;
         pc_d      = pc_q;
         opcode_d  = opcode_q;
         operand_d = operand_q;
         overrun_d = overrun_q;
         done_d    = 1'b0;
      end
   end

   // Sequencer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= '0;
         opcode_q  <= '0;
         operand_q <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         opcode_q  <= opcode_d;
         operand_q <= operand_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.instr_valid = issue_valid;
   assign bus.opcode      = opcode_q;
   assign bus.operand     = operand_q;
   assign pc_o            = pc_q;
   assign busy_o          = (state_q != S_IDLE);
   assign done_o          = done_q;
   assign overrun_o       = overrun_q;

endmodule
